mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Shares the single 256-bit memory bus (nRead/nWrite/address/data) between up to four requesters: the execution engine and the matrix/integer ALUs. Each requester posts one read or write at a time. The arbiter grants the bus to one requester, sequences the active-low strobes with the memory's fixed read latency, returns read data, and pulses completion. It sits between the requesters and the unified memory/instruction-memory model.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (2..4); requester 0 is the execution engine.
- READ_LAT, 2, edges from the nRead-low edge to the edge that samples MemDataIn.
- WRITE_CYC, 2, edges nWrite is held low.

Ports:
- Clk  in  1  clock; all state changes on posedge.
- nReset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester transaction request; held until own done.
- req_wr  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*16  per-requester address; slice i = [16i+15:16i].
- req_wdata  in  NUM_REQ*256  per-requester write data; slice i = [256i+255:256i].
- gnt  out  NUM_REQ  one-hot owner of the bus, high for the whole transaction.
- done  out  NUM_REQ  one-cycle completion pulse to the owner.
- err  out  1  one-cycle pulse with done when a write was rejected.
- rdata  out  256  read data; valid in the done cycle, held until the next read completes.
- nRead, nWrite  out  1  active-low bus strobes.
- address  out  16  bus address.
- BusDataOut  out  256  write data to memory.
- MemDataIn  in  256  read data from memory.

## Operation
- States: IDLE, READ, WRITE.
- IDLE: bus released (nRead=nWrite=1). On an edge with any req high, select a winner:
  - Round-robin search starts at the index after the last granted requester.
  - After reset, requester 0 wins first.
  - Then load gnt, the winner's address and strobe, and a counter of 0.
- READ: on the entry edge, nRead=0 and address=addr. The counter increments each edge. On the READ_LAT-th edge after entry:
  - rdata<=MemDataIn, done[i]=1, nRead=1, gnt=0, go to IDLE.
- WRITE: on the entry edge, nWrite=0, address=addr and BusDataOut=wdata. On the WRITE_CYC-th edge after entry:
  - nWrite=1, BusDataOut=0, done[i]=1, gnt=0, go to IDLE.
- Write protection: a write with addr[15]=1 (instruction memory 0x8000–0xFFFF) is not issued.
  - The grant edge goes straight to done[i]=1, err=1 with strobes untouched, and the state stays IDLE.
- Reads of any address are allowed; the execution engine fetches from 0x8000+PC.
- Only one transaction is in flight. nRead and nWrite are never low together.
- The arbiter ignores req, req_addr and req_wdata changes during a transaction.
- req still high on the done edge counts as a new request in the following IDLE cycle.
- Requests that are not selected wait with gnt=0. There is no queue depth beyond one outstanding request per requester.

## Timing
- Reset (async, immediate) outputs:
  - nRead=1, nWrite=1, address=0, BusDataOut=0.
  - gnt=0, done=0, err=0, rdata=0.
  - State IDLE; last-grant pointer = NUM_REQ-1.
- Reset mid-transaction aborts it with no done pulse. Requesters must reissue.
- Read latency: req seen at edge E, nRead low after E, data sampled and done high after E+READ_LAT. That is READ_LAT+1 edges from req to done.
- Write: done after E+WRITE_CYC. A rejected write completes after E.
- At least one IDLE cycle with both strobes high separates back-to-back transactions. Throughput is one read per READ_LAT+1 cycles.
- Simultaneous requests: exactly one is granted per IDLE cycle, by the priority rule below.
- A req raised in the same cycle another's done pulses competes in the next IDLE cycle.

## Configuration
- MEMARB_FIXED_PRIORITY_EN:
  - Defined: fixed priority, lowest index wins, so the execution engine always wins and others can starve. The last-grant pointer is unused.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset then single read: req[0]=1, addr 0x8000, MemDataIn=0x1234 from the nRead-low cycle onward -> nRead low 2 cycles, done[0] 3 edges after req, rdata=0x1234, nWrite stays 1.
- Single write: req[1], wr=1, addr 0x0010, wdata=0xABCD -> nWrite low for 2 edges with address 0x0010 and BusDataOut 0xABCD, then done[1]; BusDataOut returns to 0.
- Contention: req[0] and req[1] asserted together and held -> grants alternate 0,1,0,1 with one idle cycle between them. With MEMARB_FIXED_PRIORITY_EN, grants are 0,0,0 only.
- Protected write: req[0], wr=1, addr 0x8004 -> done[0] and err one edge later, nWrite never low.
- Reset mid-read: nReset low during READ -> nRead=1, gnt=0 immediately, no done. After release, a fresh req[1] completes normally.
- Parameter sweep READ_LAT=4: read done 5 edges after req, and data is sampled on the 4th edge after nRead low.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter: shares one 256-bit memory bus between NUM_REQ requesters.
// Optional build macro MEMARB_FIXED_PRIORITY_EN selects fixed priority.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_bus_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int READ_LAT  = 2,
  parameter int WRITE_CYC = 2
) (
  input  logic                   Clk,
  input  logic                   nReset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_wr,
  input  logic [NUM_REQ*16-1:0]  req_addr,
  input  logic [NUM_REQ*256-1:0] req_wdata,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic                   err,
  output logic [255:0]           rdata,
  output logic                   nRead,
  output logic                   nWrite,
  output logic [15:0]            address,
  output logic [255:0]           BusDataOut,
  input  logic [255:0]           MemDataIn
);

  localparam int IW = 2;
  localparam int CW = 8;
  localparam logic [CW-1:0] RD_LAST = CW'(READ_LAT - 1);
  localparam logic [CW-1:0] WR_LAST = CW'(WRITE_CYC - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               err_q, err_d;
  logic [255:0]       rdata_q, rdata_d;
  logic               nread_q, nread_d;
  logic               nwrite_q, nwrite_d;
  logic [15:0]        addr_q, addr_d;
  logic [255:0]       bdo_q, bdo_d;

  logic               win_found;
  logic [IW-1:0]      win_idx;
  logic [NUM_REQ-1:0] sel_onehot;
  logic [15:0]        sel_addr;
  logic [255:0]       sel_wdata;
  logic               sel_wr;

`ifdef MEMARB_FIXED_PRIORITY_EN
  // Lowest index wins; scanning downward lets the smallest index overwrite.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_found = 1'b1;
        win_idx   = IW'(i);
      end
    end
  end
`else
  logic [IW-1:0] last_q, last_d;

  // Search starts just after the last owner; nearest candidate is visited last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(last_q) + k) % NUM_REQ]) begin
        win_found = 1'b1;
        win_idx   = IW'((int'(last_q) + k) % NUM_REQ);
      end
    end
  end
`endif

  assign sel_onehot = NUM_REQ'(1) << win_idx;
  assign sel_addr   = req_addr[int'(win_idx)*16 +: 16];
  assign sel_wdata  = req_wdata[int'(win_idx)*256 +: 256];
  assign sel_wr     = req_wr[win_idx];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    nread_d  = nread_q;
    nwrite_d = nwrite_q;
    addr_d   = addr_q;
    bdo_d    = bdo_q;
`ifndef MEMARB_FIXED_PRIORITY_EN
    last_d   = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
`ifndef MEMARB_FIXED_PRIORITY_EN
          last_d = win_idx;
`endif
          // Instruction memory is read-only: complete with err, bus untouched.
          if (sel_wr && sel_addr[15]) begin
            done_d = sel_onehot;
            err_d  = 1'b1;
          end else begin
            gnt_d  = sel_onehot;
            addr_d = sel_addr;
            cnt_d  = '0;
            if (sel_wr) begin
              state_d  = ST_WRITE;
              nwrite_d = 1'b0;
              bdo_d    = sel_wdata;
            end else begin
              state_d = ST_READ;
              nread_d = 1'b0;
            end
          end
        end
      end
      ST_READ: begin
        if (cnt_q == RD_LAST) begin
          rdata_d = MemDataIn;
          done_d  = gnt_q;
          nread_d = 1'b1;
          gnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WRITE: begin
        if (cnt_q == WR_LAST) begin
          bdo_d    = '0;
          done_d   = gnt_q;
          nwrite_d = 1'b1;
          gnt_d    = '0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        nread_d  = 1'b1;
        nwrite_d = 1'b1;
        gnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      nread_q  <= 1'b1;
      nwrite_q <= 1'b1;
      addr_q   <= '0;
      bdo_q    <= '0;
`ifndef MEMARB_FIXED_PRIORITY_EN
      last_q   <= IW'(NUM_REQ - 1);
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      nread_q  <= nread_d;
      nwrite_q <= nwrite_d;
      addr_q   <= addr_d;
      bdo_q    <= bdo_d;
`ifndef MEMARB_FIXED_PRIORITY_EN
      last_q   <= last_d;
`endif
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign err        = err_q;
  assign rdata      = rdata_q;
  assign nRead      = nread_q;
  assign nWrite     = nwrite_q;
  assign address    = addr_q;
  assign BusDataOut = bdo_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of the arbiter. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_bus_arbiter;

  localparam int NREQ = 2;
  localparam int RL   = 2;
  localparam int WC   = 2;
`ifdef MEMARB_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic Clk = 1'b0;
  logic nReset = 1'b0;
  always #5 Clk = ~Clk;

  logic [NREQ-1:0]     req, req_wr, gnt, done;
  logic [NREQ*16-1:0]  req_addr;
  logic [NREQ*256-1:0] req_wdata;
  logic                err, nRead, nWrite;
  logic [255:0]        rdata, BusDataOut, MemDataIn;
  logic [15:0]         address;

  logic [3:0]    req4, req_wr4, gnt4, done4;
  logic [63:0]   req_addr4;
  logic [1023:0] req_wdata4;
  logic          err4, nRead4, nWrite4;
  logic [255:0]  rdata4, BusDataOut4, MemDataIn4;
  logic [15:0]   address4;

  int errors = 0;
  int checks = 0;

  logic [255:0] env_mem [32];
  logic         env_init;

  function automatic logic [255:0] init_val(int i);
    return {8{32'hC0DE_0000 | 32'(i)}};
  endfunction

  mem_bus_arbiter #(.NUM_REQ(NREQ), .READ_LAT(RL), .WRITE_CYC(WC)) u_dut (
    .Clk(Clk), .nReset(nReset), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .nRead(nRead), .nWrite(nWrite), .address(address), .BusDataOut(BusDataOut),
    .MemDataIn(MemDataIn)
  );

  mem_bus_arbiter #(.NUM_REQ(4), .READ_LAT(4), .WRITE_CYC(3)) u_dut4 (
    .Clk(Clk), .nReset(nReset), .req(req4), .req_wr(req_wr4), .req_addr(req_addr4),
    .req_wdata(req_wdata4), .gnt(gnt4), .done(done4), .err(err4), .rdata(rdata4),
    .nRead(nRead4), .nWrite(nWrite4), .address(address4), .BusDataOut(BusDataOut4),
    .MemDataIn(MemDataIn4)
  );

  // Memory environment: combinational read port, writes land while nWrite is low.
  assign MemDataIn = nRead ? {8{32'hBAD0_BAD0}} : env_mem[{address[15], address[3:0]}];

  always @(posedge Clk) begin
    if (env_init) begin
      for (int i = 0; i < 32; i++) env_mem[i] <= init_val(i);
    end else if (!nWrite) begin
      env_mem[{address[15], address[3:0]}] <= BusDataOut;
    end
  end

  task automatic test_reset;
    nReset = 1'b0; env_init = 1'b1;
    req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    req4 = '0; req_wr4 = '0; req_addr4 = '0; req_wdata4 = '0; MemDataIn4 = '0;
    repeat (3) @(negedge Clk);
    checks++; if ({nRead, nWrite} !== 2'b11) begin errors++; $display("FAIL reset_strobes: got %b want 11", {nRead, nWrite}); end
    checks++; if (address !== 16'h0) begin errors++; $display("FAIL reset_address: got %h want 0", address); end
    checks++; if (BusDataOut !== 256'h0) begin errors++; $display("FAIL reset_busdata: got %h want 0", BusDataOut); end
    checks++; if ({gnt, done, err} !== 5'b0) begin errors++; $display("FAIL reset_gnt_done_err: got %b want 0", {gnt, done, err}); end
    checks++; if (rdata !== 256'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    nReset = 1'b1; env_init = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_single_read;
    req[0] = 1'b1; req_wr[0] = 1'b0; req_addr[15:0] = 16'h8000;
    for (int c = 1; c <= 3; c++) begin
      @(negedge Clk);
      checks++; if (nRead !== ((c < 3) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL rd_nRead c%0d: got %b", c, nRead); end
      checks++; if (nWrite !== 1'b1) begin errors++; $display("FAIL rd_nWrite c%0d: got %b want 1", c, nWrite); end
      checks++; if (done !== ((c == 3) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL rd_done c%0d: got %b", c, done); end
      if (c == 1) begin
        checks++; if ({gnt, address} !== {2'b01, 16'h8000}) begin errors++; $display("FAIL rd_gnt_addr: got %h want 18000", {gnt, address}); end
      end
    end
    checks++; if (rdata !== init_val(16)) begin errors++; $display("FAIL rd_rdata: got %h want %h", rdata, init_val(16)); end
    req[0] = 1'b0;
    @(negedge Clk);
    checks++; if (done !== 2'b00) begin errors++; $display("FAIL rd_done_clear: got %b want 00", done); end
  endtask

  task automatic test_single_write;
    req[1] = 1'b1; req_wr[1] = 1'b1; req_addr[31:16] = 16'h0010; req_wdata[511:256] = 256'hABCD;
    for (int c = 1; c <= 3; c++) begin
      @(negedge Clk);
      if (c < 3) begin
        checks++; if ({gnt, nWrite, nRead, address} !== {2'b10, 1'b0, 1'b1, 16'h0010}) begin errors++; $display("FAIL wr_bus c%0d: got %h", c, {gnt, nWrite, nRead, address}); end
        checks++; if (BusDataOut !== 256'hABCD) begin errors++; $display("FAIL wr_busdata c%0d: got %h want abcd", c, BusDataOut); end
      end else begin
        checks++; if ({done, err, nWrite, gnt} !== {2'b10, 1'b0, 1'b1, 2'b00}) begin errors++; $display("FAIL wr_done: got %b want 100100", {done, err, nWrite, gnt}); end
        checks++; if (BusDataOut !== 256'h0) begin errors++; $display("FAIL wr_busdata_clear: got %h want 0", BusDataOut); end
      end
    end
    req[1] = 1'b0; req_wr[1] = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_contention;
    int seq [4];
    int n = 0;
    logic [NREQ-1:0] prev = '0;
    req = 2'b11; req_wr = 2'b00; req_addr = {16'h0002, 16'h0001};
    for (int c = 1; c <= 12; c++) begin
      @(negedge Clk);
      if (gnt !== 2'b00 && prev === 2'b00 && n < 4) begin
        seq[n] = gnt[1] ? 1 : 0;
        n++;
      end
      if (done !== 2'b00) begin
        checks++; if ({nRead, nWrite, gnt} !== 4'b1100) begin errors++; $display("FAIL cont_idle c%0d: got %b want 1100", c, {nRead, nWrite, gnt}); end
      end
      prev = gnt;
      if (c == 12) req = 2'b00;
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL cont_count: got %0d want 4", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (seq[i] !== (FIXED ? 0 : i % 2)) begin errors++; $display("FAIL cont_order[%0d]: got %0d want %0d", i, seq[i], FIXED ? 0 : i % 2); end
    end
    @(negedge Clk);
  endtask

  task automatic test_protected_write;
    req[0] = 1'b1; req_wr[0] = 1'b1; req_addr[15:0] = 16'h8004; req_wdata[255:0] = 256'h77;
    @(negedge Clk);
    checks++; if ({done, err, nWrite, gnt} !== {2'b01, 1'b1, 1'b1, 2'b00}) begin errors++; $display("FAIL prot_done: got %b want 011100", {done, err, nWrite, gnt}); end
    req[0] = 1'b0; req_wr[0] = 1'b0;
    @(negedge Clk);
    checks++; if ({done, err, nWrite} !== 4'b0001) begin errors++; $display("FAIL prot_after: got %b want 0001", {done, err, nWrite}); end
  endtask

  task automatic test_reset_mid_read;
    req[0] = 1'b1; req_wr[0] = 1'b0; req_addr[15:0] = 16'h0003;
    @(negedge Clk);
    checks++; if (nRead !== 1'b0) begin errors++; $display("FAIL mid_nRead_low: got %b want 0", nRead); end
    #2 nReset = 1'b0;
    #1;
    checks++; if ({nRead, gnt, done} !== 5'b10000) begin errors++; $display("FAIL mid_async: got %b want 10000", {nRead, gnt, done}); end
    req[0] = 1'b0;
    @(negedge Clk);
    checks++; if (done !== 2'b00) begin errors++; $display("FAIL mid_no_done: got %b want 00", done); end
    nReset = 1'b1;
    req[1] = 1'b1; req_wr[1] = 1'b0; req_addr[31:16] = 16'h0004;
    for (int c = 1; c <= 3; c++) begin
      @(negedge Clk);
      if (c == 1) begin
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL mid_regrant: got %b want 10", gnt); end
      end
      checks++; if (done !== ((c == 3) ? 2'b10 : 2'b00)) begin errors++; $display("FAIL mid_done c%0d: got %b", c, done); end
    end
    checks++; if (rdata !== init_val(4)) begin errors++; $display("FAIL mid_rdata: got %h want %h", rdata, init_val(4)); end
    req[1] = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_lat4;
    int low = 0;
    req4[2] = 1'b1; req_wr4[2] = 1'b0; req_addr4[47:32] = 16'h0020;
    for (int c = 1; c <= 5; c++) begin
      @(negedge Clk);
      if (nRead4 === 1'b0) low++;
      MemDataIn4 = 256'(low);
      if (c == 1) begin
        checks++; if (gnt4 !== 4'b0100) begin errors++; $display("FAIL lat4_gnt: got %b want 0100", gnt4); end
      end
      checks++; if (done4 !== ((c == 5) ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL lat4_done c%0d: got %b", c, done4); end
    end
    checks++; if (rdata4 !== 256'd4) begin errors++; $display("FAIL lat4_sample_edge: got %0d want 4", rdata4); end
    checks++; if (low !== 4) begin errors++; $display("FAIL lat4_nRead_cycles: got %0d want 4", low); end
    req4[2] = 1'b0;
    req4[3] = 1'b1; req_wr4[3] = 1'b1; req_addr4[63:48] = 16'h0030; req_wdata4[1023:768] = 256'h55;
    for (int c = 1; c <= 4; c++) begin
      @(negedge Clk);
      checks++; if ({done4, nWrite4} !== ((c == 4) ? 5'b10001 : 5'b00000)) begin errors++; $display("FAIL wc3_write c%0d: got %b", c, {done4, nWrite4}); end
    end
    req4[3] = 1'b0;
    @(negedge Clk);
  endtask

  // Transaction-level model: a bus owner keeps the bus for its latency, then one
  // free cycle; winners chosen by rotating (or fixed) priority over live requests.
  task automatic test_random(input int ncyc);
    logic [255:0]    mmem [32];
    logic            granted [NREQ];
    int              g_at [NREQ];
    int              d_at [NREQ];
    logic            x_err [NREQ];
    logic            x_rd [NREQ];
    logic [15:0]     x_addr [NREQ];
    logic [255:0]    x_rdata [NREQ];
    logic [NREQ-1:0] xg, xd;
    logic            xnr, xnw, xerr;
    logic [4:0]      idx;
    int              last, free_at, t, w, d;
    nReset = 1'b0; env_init = 1'b1; req = '0;
    repeat (2) @(negedge Clk);
    nReset = 1'b1; env_init = 1'b0;
    for (int i = 0; i < 32; i++) mmem[i] = init_val(i);
    for (int i = 0; i < NREQ; i++) begin granted[i] = 1'b0; g_at[i] = 0; d_at[i] = 0; end
    last = NREQ - 1;
    free_at = 1;
    for (int e = 1; e <= ncyc; e++) begin
      @(negedge Clk);
      xg = '0; xd = '0; xnr = 1'b1; xnw = 1'b1; xerr = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (granted[i] && g_at[i] <= e && e < d_at[i]) begin
          xg[i] = 1'b1;
          if (x_rd[i]) xnr = 1'b0; else xnw = 1'b0;
        end
        if (granted[i] && d_at[i] == e) begin
          xd[i] = 1'b1;
          xerr = x_err[i];
        end
      end
      checks++; if (gnt !== xg) begin errors++; $display("FAIL rnd_gnt cyc%0d: got %b want %b", e, gnt, xg); end
      checks++; if (done !== xd) begin errors++; $display("FAIL rnd_done cyc%0d: got %b want %b", e, done, xd); end
      checks++; if ({nRead, nWrite} !== {xnr, xnw}) begin errors++; $display("FAIL rnd_strobes cyc%0d: got %b want %b", e, {nRead, nWrite}, {xnr, xnw}); end
      checks++; if (err !== xerr) begin errors++; $display("FAIL rnd_err cyc%0d: got %b want %b", e, err, xerr); end
      for (int i = 0; i < NREQ; i++) begin
        if (xg[i]) begin
          checks++; if (address !== x_addr[i]) begin errors++; $display("FAIL rnd_addr cyc%0d: got %h want %h", e, address, x_addr[i]); end
        end
        if (xd[i] && x_rd[i]) begin
          checks++; if (rdata !== x_rdata[i]) begin errors++; $display("FAIL rnd_rdata cyc%0d: got %h want %h", e, rdata, x_rdata[i]); end
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (xd[i]) begin granted[i] = 1'b0; req[i] = 1'b0; end
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          req_wr[i] = 1'($urandom_range(0, 1));
          req_addr[16*i +: 16] = {1'($urandom_range(0, 1)), 11'h0, 4'($urandom_range(0, 15))};
          req_wdata[256*i +: 256] = {8{$urandom()}};
        end else if (granted[i] && $urandom_range(0, 3) == 0) begin
          req_wr[i] = ~req_wr[i];
          req_addr[16*i +: 16] = 16'($urandom());
          req_wdata[256*i +: 256] = {8{$urandom()}};
        end
      end
      t = e + 1;
      if (t >= free_at && req != '0) begin
        w = -1;
        if (FIXED) begin
          for (int i = NREQ - 1; i >= 0; i--) if (req[i]) w = i;
        end else begin
          for (int k = NREQ; k >= 1; k--) if (req[(last + k) % NREQ]) w = (last + k) % NREQ;
        end
        granted[w] = 1'b1;
        g_at[w]    = t;
        x_addr[w]  = req_addr[16*w +: 16];
        x_rd[w]    = !req_wr[w];
        x_err[w]   = req_wr[w] && x_addr[w][15];
        d          = x_err[w] ? 0 : (x_rd[w] ? RL : WC);
        d_at[w]    = t + d;
        idx        = {x_addr[w][15], x_addr[w][3:0]};
        if (x_rd[w]) x_rdata[w] = mmem[idx];
        else if (!x_err[w]) mmem[idx] = req_wdata[256*w +: 256];
        last    = w;
        free_at = t + d + 1;
      end
    end
    req = '0;
    repeat (6) @(negedge Clk);
  endtask

  initial begin
    env_init = 1'b1;
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_protected_write();
    test_reset_mid_read();
    test_lat4();
    test_random(400);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
